// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for a two-digit 7-segment display sharing
// one segment bus. Each digit gets a lit slot of SCAN_DIV cycles, preceded by
// a BLANK_CYC dead-time where both selects are off, to avoid ghosting.
// Upstream writes land in pending registers and are copied into the active
// registers only when the scan enters that digit's blanking slot, so a lit
// digit never changes mid-slot.
//
// Parameters:
//   SCAN_DIV   lit slot length per digit, in clk cycles (>= 2)
//   BLANK_CYC  dead-time before each lit slot, in clk cycles (>= 1)
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   wr_en      write strobe, one write per asserted cycle
//   wr_addr    target digit (0 = digit 1, 1 = digit 2)
//   wr_data    hex value to display
//   digit_on   per-digit enable, sampled live (bit0 = digit 1, bit1 = digit 2)
//   sm_cs1_n   digit 1 select, active-low, registered
//   sm_cs2_n   digit 2 select, active-low, registered
//   sm_db      segments {g..a}, active-high, registered
//   frame_done one-cycle pulse on entering BLANK0 from SHOW1

module seg7_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic       wr_addr,
    input  logic [3:0] wr_data,
    input  logic [1:0] digit_on,
    output logic       sm_cs1_n,
    output logic       sm_cs2_n,
    output logic [6:0] sm_db,
    output logic       frame_done
);

    localparam int MAX_LEN = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = $clog2(MAX_LEN);

    localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        BLANK0 = 2'd0,
        SHOW0  = 2'd1,
        BLANK1 = 2'd2,
        SHOW1  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] len_m1;
    logic          slot_end;
    logic          run_en;
    logic [3:0]    pend [2];
    logic [3:0]    act  [2];

    // Hex to {g..a} segment pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        logic [6:0] s;
        s = 7'h00;
        case (v)
            4'h0: s = 7'h3f;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5b;
            4'h3: s = 7'h4f;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6d;
            4'h6: s = 7'h7d;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7f;
            4'h9: s = 7'h6f;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7c;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5e;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Slot length depends on whether we are blanking or showing. run_en holds
    // the counter for the first edge after reset release so that edge is
    // counter 0 of BLANK0, giving BLANK0 its full BLANK_CYC edges.
    always_comb begin
        len_m1   = (state == BLANK0 || state == BLANK1) ? BLANK_LAST : SHOW_LAST;
        slot_end = run_en && (cnt == len_m1);
        state_nx = state;
        if (slot_end) begin
            case (state)
                BLANK0:  state_nx = SHOW0;
                SHOW0:   state_nx = BLANK1;
                BLANK1:  state_nx = SHOW1;
                SHOW1:   state_nx = BLANK0;
                default: state_nx = BLANK0;
            endcase
        end
    end

    // Scan FSM, digit storage and registered outputs. Outputs are decoded from
    // the next state so they switch on the same edge as the state itself.
    // A write sampled on a BLANKk entry edge is forwarded straight into act[k].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BLANK0;
            cnt        <= '0;
            run_en     <= 1'b0;
            pend[0]    <= 4'h0;
            pend[1]    <= 4'h0;
            act[0]     <= 4'h0;
            act[1]     <= 4'h0;
            sm_cs1_n   <= 1'b1;
            sm_cs2_n   <= 1'b1;
            sm_db      <= 7'h00;
            frame_done <= 1'b0;
        end else begin
            run_en <= 1'b1;
            state  <= state_nx;

            if (wr_en) begin
                pend[wr_addr] <= wr_data;
            end

            if (slot_end) begin
                cnt <= '0;
            end else if (run_en) begin
                cnt <= cnt + CW'(1);
            end

            if (slot_end && state_nx == BLANK0) begin
                act[0] <= (wr_en && !wr_addr) ? wr_data : pend[0];
            end
            if (slot_end && state_nx == BLANK1) begin
                act[1] <= (wr_en && wr_addr) ? wr_data : pend[1];
            end

            frame_done <= slot_end && (state == SHOW1);

            sm_cs1_n <= 1'b1;
            sm_cs2_n <= 1'b1;
            sm_db    <= 7'h00;
            case (state_nx)
                SHOW0: begin
                    if (digit_on[0]) begin
                        sm_cs1_n <= 1'b0;
                        sm_db    <= seg_decode(act[0]);
                    end
                end
                SHOW1: begin
                    if (digit_on[1]) begin
                        sm_cs2_n <= 1'b0;
                        sm_db    <= seg_decode(act[1]);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
